// File: rtl/speedhandler_pkg.sv
// Shared constants for the DShot150 speed handler.
// Frame field positions, special-command limit and default timing.
package speedhandler_pkg;

  localparam int DEF_CLKS_PER_US   = 16;
  localparam int DEF_BIT_THRESHOLD = 60;
  localparam int DEF_FRAME_TIMEOUT = 160;

  localparam int FRAME_BITS    = 16;
  localparam int THR_MSB       = 15;
  localparam int THR_LSB       = 5;
  localparam int TLM_BIT       = 4;
  localparam int CRC_MSB       = 3;
  localparam int SPECIAL_LIMIT = 48;

  typedef enum logic {
    RX_IDLE,
    RX_FRAME
  } rx_state_e;

  function automatic logic [3:0] crc4(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/speedhandler_bit_rx.sv
// DShot line receiver: synchronizer, level timing, bit and frame strobes.
// A frame is aborted when the line sits at one level too long mid-frame.
import speedhandler_pkg::*;

module dshot_bit_rx #(
  parameter int CLKS_PER_US   = DEF_CLKS_PER_US,
  parameter int BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic dshot_pin,
  output logic bit_valid,
  output logic bit_val,
  output logic frame_done,
  output logic processing
);

  // Level counter saturates one microsecond past the timeout.
  localparam int CNT_MAX = FRAME_TIMEOUT + CLKS_PER_US;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(BIT_THRESHOLD);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(FRAME_TIMEOUT);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic [1:0] sync_q;
  logic prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  rx_state_e state_q, state_d;
  logic rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      state_q   <= RX_IDLE;
    end else begin
      sync_q    <= {sync_q[0], dshot_pin};
      prev_q    <= sync_q[1];
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    rise = sync_q[1] & ~prev_q;
    fall = ~sync_q[1] & prev_q;
    // cnt_q equals the clocks spent at the current level
    if (rise || fall)
      cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_SAT)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_valid  = 1'b0;
    frame_done = 1'b0;
    bit_val    = (cnt_q > THR_C);
    case (state_q)
      RX_IDLE: begin
        if (rise) begin
          state_d   = RX_FRAME;
          bit_cnt_d = '0;
        end
      end
      RX_FRAME: begin
        if (fall) begin
          bit_valid = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            frame_done = 1'b1;
            bit_cnt_d  = '0;
            state_d    = RX_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (cnt_q > TO_C) begin
          bit_cnt_d = '0;
          state_d   = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign processing = (state_q == RX_FRAME);

endmodule

// File: rtl/speedhandler.sv
// DShot150 frame decoder: shift register, CRC check and output registers.
// Decoding happens one clock after the frame-done strobe.
import speedhandler_pkg::*;

module speedhandler #(
  parameter int CLKS_PER_US   = DEF_CLKS_PER_US,
  parameter int BIT_THRESHOLD = DEF_BIT_THRESHOLD,
  parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dshotPin,
  output logic [7:0] outputSpeed,
  output logic [5:0] specialCommand,
  output logic       isSpecialCommand,
  output logic       isValidSpeed,
  output logic       CRCValid,
  output logic       telemetryBit,
  output logic       processing
);

  logic bit_valid, bit_val, frame_done;

  dshot_bit_rx #(
    .CLKS_PER_US  (CLKS_PER_US),
    .BIT_THRESHOLD(BIT_THRESHOLD),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .dshot_pin (dshotPin),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .frame_done(frame_done),
    .processing(processing)
  );

  logic [15:0] shift_q, shift_d;
  logic done_q, done_d;
  logic [7:0] speed_q, speed_d;
  logic [5:0] cmd_q, cmd_d;
  logic is_spec_q, is_spec_d;
  logic valid_q, valid_d;
  logic crc_q, crc_d;
  logic tlm_q, tlm_d;

  logic [10:0] throttle;
  logic crc_ok, thr_zero, thr_spec, thr_speed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      done_q    <= 1'b0;
      speed_q   <= '0;
      cmd_q     <= '0;
      is_spec_q <= 1'b0;
      valid_q   <= 1'b0;
      crc_q     <= 1'b0;
      tlm_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      done_q    <= done_d;
      speed_q   <= speed_d;
      cmd_q     <= cmd_d;
      is_spec_q <= is_spec_d;
      valid_q   <= valid_d;
      crc_q     <= crc_d;
      tlm_q     <= tlm_d;
    end
  end

  always_comb begin
    shift_d   = bit_valid ? {shift_q[14:0], bit_val} : shift_q;
    done_d    = frame_done;
    throttle  = shift_q[THR_MSB:THR_LSB];
    crc_ok    = crc4(shift_q[THR_MSB:TLM_BIT]) == shift_q[CRC_MSB:0];
    thr_zero  = (throttle == 11'd0);
    thr_spec  = !thr_zero && (throttle < 11'(SPECIAL_LIMIT));
    thr_speed = (throttle >= 11'(SPECIAL_LIMIT));
    speed_d   = speed_q;
    cmd_d     = cmd_q;
    is_spec_d = is_spec_q;
    valid_d   = valid_q;
    crc_d     = crc_q;
    tlm_d     = tlm_q;
    if (done_q) begin
      crc_d = crc_ok;
      if (crc_ok) begin
        tlm_d = shift_q[TLM_BIT];
        unique case (1'b1)
          thr_zero: begin
            speed_d   = '0;
            valid_d   = 1'b1;
            is_spec_d = 1'b0;
          end
          thr_spec: begin
            cmd_d     = throttle[5:0];
            is_spec_d = 1'b1;
            valid_d   = 1'b0;
          end
          thr_speed: begin
            speed_d   = throttle[10:3];
            valid_d   = 1'b1;
            is_spec_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign outputSpeed      = speed_q;
  assign specialCommand   = cmd_q;
  assign isSpecialCommand = is_spec_q;
  assign isValidSpeed     = valid_q;
  assign CRCValid         = crc_q;
  assign telemetryBit     = tlm_q;

endmodule

// File: tb/tb_speedhandler.sv
// Self-checking bench for speedhandler: directed DShot frames plus
// randomized frames against a frame-level reference model.
module tb_speedhandler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b0;
  logic [7:0] outputSpeed;
  logic [5:0] specialCommand;
  logic isSpecialCommand, isValidSpeed, CRCValid, telemetryBit, processing;

  speedhandler dut (
    .clk             (clk),
    .rst             (rst),
    .dshotPin        (pin),
    .outputSpeed     (outputSpeed),
    .specialCommand  (specialCommand),
    .isSpecialCommand(isSpecialCommand),
    .isValidSpeed    (isValidSpeed),
    .CRCValid        (CRCValid),
    .telemetryBit    (telemetryBit),
    .processing      (processing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int exp_speed, exp_cmd, exp_isspec, exp_valid, exp_crc, exp_tlm, exp_proc;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_speed = 0; exp_cmd = 0; exp_isspec = 0; exp_valid = 0;
    exp_crc = 0; exp_tlm = 0; exp_proc = 0;
  endtask

  task automatic model_frame(input int f);
    int v, crc, thr;
    v = f >> 4;
    crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
    thr = f >> 5;
    exp_crc = (crc == (f & 15)) ? 1 : 0;
    if (exp_crc == 1) begin
      exp_tlm = (f >> 4) & 1;
      if (thr == 0) begin
        exp_speed = 0; exp_valid = 1; exp_isspec = 0;
      end else if (thr < 48) begin
        exp_cmd = thr; exp_isspec = 1; exp_valid = 0;
      end else begin
        exp_speed = thr / 8; exp_valid = 1; exp_isspec = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("speed", 16'(outputSpeed), 16'(exp_speed));
      check("cmd", 16'(specialCommand), 16'(exp_cmd));
      check("isspec", 16'(isSpecialCommand), 16'(exp_isspec));
      check("valid", 16'(isValidSpeed), 16'(exp_valid));
      check("crc", 16'(CRCValid), 16'(exp_crc));
      check("tlm", 16'(telemetryBit), 16'(exp_tlm));
      check("proc", 16'(processing), 16'(exp_proc));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int hi, lo;
      hi = f[15-i] ? 80 : 40;
      lo = 107 - hi;
      pin = 1'b1;
      if (i == 0) begin
        chk_en = 1'b0;
        tick(8);
        exp_proc = 1;
        chk_en = 1'b1;
        tick(hi - 8);
      end else begin
        tick(hi);
      end
      pin = 1'b0;
      if (i == 15) begin
        chk_en = 1'b0;
        tick(10);
        model_frame(int'(f));
        exp_proc = 0;
        chk_en = 1'b1;
        tick(lo - 10);
      end else begin
        tick(lo);
      end
    end
  endtask

  task automatic idle_abort();
    chk_en = 1'b0;
    tick(200);
    exp_proc = 0;
    chk_en = 1'b1;
    tick(120);
  endtask

  task automatic high_abort();
    pin = 1'b1;
    chk_en = 1'b0;
    tick(200);
    exp_proc = 0;
    chk_en = 1'b1;
    pin = 1'b0;
    tick(100);
  endtask

  initial begin
    logic [15:0] f;
    int thr, v;
    model_reset();
    rst = 1'b1;
    tick(3);
    #1;
    check("rst_speed", 16'(outputSpeed), 16'h0);
    check("rst_cmd", 16'(specialCommand), 16'h0);
    check("rst_isspec", 16'(isSpecialCommand), 16'h0);
    check("rst_valid", 16'(isValidSpeed), 16'h0);
    check("rst_crc", 16'(CRCValid), 16'h0);
    check("rst_tlm", 16'(telemetryBit), 16'h0);
    check("rst_proc", 16'(processing), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(5);

    send_frame(16'hDEA9, 16);
    #1;
    check("dea9_speed", 16'(outputSpeed), 16'h00DE);
    check("dea9_crc", 16'(CRCValid), 16'h1);
    check("dea9_valid", 16'(isValidSpeed), 16'h1);
    check("dea9_tlm", 16'(telemetryBit), 16'h0);

    send_frame(16'hFFEE, 16);
    #1;
    check("ffee_speed", 16'(outputSpeed), 16'h00FF);
    check("ffee_crc", 16'(CRCValid), 16'h1);
    check("ffee_tlm", 16'(telemetryBit), 16'h0);

    send_frame(16'hDEA9, 16);
    send_frame(16'hDEA8, 16);
    #1;
    check("dea8_crc", 16'(CRCValid), 16'h0);
    check("dea8_speed", 16'(outputSpeed), 16'h00DE);

    send_frame(16'h00BB, 16);
    #1;
    check("bb_isspec", 16'(isSpecialCommand), 16'h1);
    check("bb_cmd", 16'(specialCommand), 16'd5);
    check("bb_tlm", 16'(telemetryBit), 16'h1);
    check("bb_speed", 16'(outputSpeed), 16'h00DE);
    send_frame(16'h0000, 16);
    #1;
    check("zero_speed", 16'(outputSpeed), 16'h0);
    check("zero_isspec", 16'(isSpecialCommand), 16'h0);

    send_frame(16'hDEA9, 8);
    idle_abort();
    #1;
    check("idle_proc", 16'(processing), 16'h0);
    check("idle_speed", 16'(outputSpeed), 16'h0);
    send_frame(16'hFFEE, 16);
    #1;
    check("after_idle_speed", 16'(outputSpeed), 16'h00FF);

    send_frame(16'hDEA9, 5);
    high_abort();
    #1;
    check("high_abort_speed", 16'(outputSpeed), 16'h00FF);

    send_frame(16'hDEA9, 10);
    chk_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_speed", 16'(outputSpeed), 16'h0);
    check("mid_rst_crc", 16'(CRCValid), 16'h0);
    check("mid_rst_valid", 16'(isValidSpeed), 16'h0);
    check("mid_rst_proc", 16'(processing), 16'h0);
    model_reset();
    tick(3);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(5);
    send_frame(16'hDEA9, 16);
    #1;
    check("post_rst_speed", 16'(outputSpeed), 16'h00DE);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: thr = 0;
        1: thr = int'($urandom_range(1, 47));
        default: thr = int'($urandom_range(48, 2047));
      endcase
      v = (thr << 1) | int'($urandom_range(0, 1));
      v = (v << 4) | ((v ^ (v >> 4) ^ (v >> 8)) & 15);
      if ($urandom_range(0, 4) == 0)
        v = v ^ int'($urandom_range(1, 15));
      f = 16'(v);
      if ($urandom_range(0, 9) == 0) begin
        send_frame(16'($urandom), int'($urandom_range(1, 15)));
        if ($urandom_range(0, 1) == 0) idle_abort();
        else high_abort();
      end
      send_frame(f, 16);
      tick(int'($urandom_range(0, 100)));
    end

    chk_en = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
